// File: rtl/if_id_skid_reg_pkg.sv
// Shared definitions for the IF->ID pipeline register: default widths,
// the architectural NOP encoding and the occupancy state encoding.
package if_id_skid_reg_pkg;

    localparam int          DEF_INST_W = 32;
    localparam int          DEF_ADDR_W = 32;
    localparam logic [31:0] INST_NOP   = 32'h00000013;

    typedef enum logic [1:0] {
        IFID_EMPTY = 2'd0,
        IFID_FULL  = 2'd1,
        IFID_SKID  = 2'd2
    } ifid_state_e;

endpackage

// File: rtl/if_id_skid_reg_dff_en_async.sv
// Enabled register with asynchronous active-low reset to a parameterised value.
module dff_en_async #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= RST_VAL;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/if_id_skid_reg.sv
// IF->ID pipeline register with valid/ready handshake, a one-deep skid entry
// behind the output entry, and a synchronous flush that squashes both.
module if_id_skid_reg
    import if_id_skid_reg_pkg::*;
#(
    parameter int                INST_W   = DEF_INST_W,
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(INST_NOP)
) (
    input  logic              sys_clk_i,
    input  logic              rst_n_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [ADDR_W-1:0] instruction_addr_i,
    input  logic [INST_W-1:0] instruction_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ADDR_W-1:0] instruction_addr_o,
    output logic [INST_W-1:0] instruction_o
);

    // Entry layout: {valid, addr, inst}; a cleared entry reads as NOP at address 0.
    localparam int               ENT_W   = 1 + ADDR_W + INST_W;
    localparam logic [ENT_W-1:0] ENT_CLR = {1'b0, {ADDR_W{1'b0}}, NOP_INST};

    ifid_state_e      r_state;
    ifid_state_e      w_state_next;
    logic             r_in_ready;
    logic             w_in_fire;
    logic             w_out_fire;
    logic [ENT_W-1:0] w_in_ent;
    logic [ENT_W-1:0] w_main_q;
    logic [ENT_W-1:0] w_main_d;
    logic             w_main_en;
    logic [ENT_W-1:0] w_skid_q;
    logic [ENT_W-1:0] w_skid_d;
    logic             w_skid_en;

    assign w_in_ent   = {1'b1, instruction_addr_i, instruction_i};
    assign w_in_fire  = in_valid_i & r_in_ready;
    assign w_out_fire = w_main_q[ENT_W-1] & out_ready_i;

    always_comb begin
        w_state_next = r_state;
        w_main_en    = 1'b0;
        w_main_d     = ENT_CLR;
        w_skid_en    = 1'b0;
        w_skid_d     = ENT_CLR;
        if (flush_i) begin
            w_state_next = IFID_EMPTY;
            w_main_en    = 1'b1;
            w_skid_en    = 1'b1;
        end else begin
            case (r_state)
                IFID_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_next = IFID_FULL;
                        w_main_en    = 1'b1;
                        w_main_d     = w_in_ent;
                    end
                end
                IFID_FULL: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_en = 1'b1;
                        w_main_d  = w_in_ent;
                    end else if (w_out_fire) begin
                        w_state_next = IFID_EMPTY;
                        w_main_en    = 1'b1;
                    end else if (w_in_fire) begin
                        w_state_next = IFID_SKID;
                        w_skid_en    = 1'b1;
                        w_skid_d     = w_in_ent;
                    end
                end
                IFID_SKID: begin
                    if (w_out_fire) begin
                        w_state_next = IFID_FULL;
                        w_main_en    = 1'b1;
                        w_main_d     = w_skid_q;
                        w_skid_en    = 1'b1;
                    end
                end
                default: begin
                    w_state_next = IFID_EMPTY;
                    w_main_en    = 1'b1;
                    w_skid_en    = 1'b1;
                end
            endcase
        end
    end

    // Ready is registered from the next state so out_ready_i never reaches IF combinationally.
    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= IFID_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next != IFID_SKID);
        end
    end

    dff_en_async #(
        .WIDTH   (ENT_W),
        .RST_VAL (ENT_CLR)
    ) u_main (
        .i_clk   (sys_clk_i),
        .i_rst_n (rst_n_i),
        .i_en    (w_main_en),
        .i_d     (w_main_d),
        .o_q     (w_main_q)
    );

    dff_en_async #(
        .WIDTH   (ENT_W),
        .RST_VAL (ENT_CLR)
    ) u_skid (
        .i_clk   (sys_clk_i),
        .i_rst_n (rst_n_i),
        .i_en    (w_skid_en),
        .i_d     (w_skid_d),
        .o_q     (w_skid_q)
    );

    assign in_ready_o         = r_in_ready;
    assign out_valid_o        = w_main_q[ENT_W-1];
    assign instruction_addr_o = w_main_q[ADDR_W+INST_W-1:INST_W];
    assign instruction_o      = w_main_q[INST_W-1:0];

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Scoreboard bench for if_id_skid_reg: a queue of held instructions models the
// block; a negedge monitor compares the DUT outputs against the queue head.
module tb_if_id_skid_reg;

    localparam int          IW  = 32;
    localparam int          AW  = 32;
    localparam logic [31:0] NOP = 32'h00000013;

    logic          sys_clk_i = 1'b0;
    logic          rst_n_i;
    logic          flush_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [AW-1:0] instruction_addr_i;
    logic [IW-1:0] instruction_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [AW-1:0] instruction_addr_o;
    logic [IW-1:0] instruction_o;

    always #5 sys_clk_i = ~sys_clk_i;

    if_id_skid_reg #(
        .INST_W   (IW),
        .ADDR_W   (AW),
        .NOP_INST (NOP)
    ) dut (
        .sys_clk_i          (sys_clk_i),
        .rst_n_i            (rst_n_i),
        .flush_i            (flush_i),
        .in_valid_i         (in_valid_i),
        .in_ready_o         (in_ready_o),
        .instruction_addr_i (instruction_addr_i),
        .instruction_i      (instruction_i),
        .out_valid_o        (out_valid_o),
        .out_ready_i        (out_ready_i),
        .instruction_addr_o (instruction_addr_o),
        .instruction_o      (instruction_o)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [IW-1:0] inst;
    } item_t;

    item_t exp_q[$];
    int    checks     = 0;
    int    errors     = 0;
    bit    stall_prev = 1'b0;
    bit    verbose    = 1'b1;
    item_t last_out;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: the held queue defines what the DUT must present this cycle.
    always @(negedge sys_clk_i) begin
        bit    ev;
        item_t head;
        ev = (exp_q.size() > 0);
        chk("out_valid", out_valid_o, ev);
        chk("in_ready", in_ready_o, exp_q.size() < 2);
        if (ev) begin
            head = exp_q[0];
            chk("out_addr", instruction_addr_o, head.addr);
            chk("out_inst", instruction_o, head.inst);
        end else begin
            chk("idle_addr", instruction_addr_o, 0);
            chk("idle_inst", instruction_o, NOP);
        end
        if (stall_prev) begin
            chk("stall_addr", instruction_addr_o, last_out.addr);
            chk("stall_inst", instruction_o, last_out.inst);
        end
        last_out = {instruction_addr_o, instruction_o};
    end

    // One clock of stimulus; the model updates from the same inputs at the edge.
    task automatic step(input bit v, input logic [31:0] a, input logic [31:0] ins,
                        input bit ordy, input bit fl);
        int    n;
        item_t it;
        in_valid_i         = v;
        instruction_addr_i = a;
        instruction_i      = ins;
        out_ready_i        = ordy;
        flush_i            = fl;
        @(posedge sys_clk_i);
        n          = exp_q.size();
        stall_prev = (n > 0) && !ordy && !fl;
        if (n > 0 && ordy) begin
            it = exp_q[0];
            if (verbose) $display("consume addr=%08h inst=%08h flush=%0d", it.addr, it.inst, fl);
        end
        if (fl) begin
            exp_q.delete();
        end else begin
            if (n > 0 && ordy) void'(exp_q.pop_front());
            if (v && n < 2) begin
                exp_q.push_back({a, ins});
                if (verbose) $display("accept  addr=%08h inst=%08h", a, ins);
            end
        end
        @(negedge sys_clk_i);
    endtask

    initial begin
        logic [31:0] pc;
        bit          rv, ro, rf;
        rst_n_i            = 1'b0;
        flush_i            = 1'b0;
        in_valid_i         = 1'b0;
        out_ready_i        = 1'b0;
        instruction_addr_i = '0;
        instruction_i      = '0;
        repeat (2) @(negedge sys_clk_i);
        rst_n_i = 1'b1;

        // Streaming, one-cycle latency, back-to-back
        step(1, 32'h0, 32'h00500093, 1, 0);
        step(1, 32'h4, 32'h00100113, 1, 0);
        step(1, 32'h8, 32'h002081B3, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0);

        // Asynchronous reset while FULL
        step(1, 32'h40, 32'h11111111, 0, 0);
        chk("pre_rst_valid", out_valid_o, 1);
        #2;
        rst_n_i = 1'b0;
        exp_q.delete();
        stall_prev = 1'b0;
        #1;
        chk("rst_valid", out_valid_o, 0);
        chk("rst_ready", in_ready_o, 1);
        chk("rst_inst", instruction_o, NOP);
        chk("rst_addr", instruction_addr_o, 0);
        @(negedge sys_clk_i);
        rst_n_i = 1'b1;

        // Backpressure into the skid entry, then drain in order
        step(1, 32'h10, 32'hAAAA0001, 0, 0);
        step(1, 32'h14, 32'hBBBB0002, 0, 0);
        chk("bp_in_ready", in_ready_o, 0);
        step(1, 32'h99, 32'hDEADBEEF, 0, 0);
        step(0, 32'h0, 32'h0, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0);

        // Flush in SKID with a simultaneous input
        step(1, 32'h10, 32'hAAAA0001, 0, 0);
        step(1, 32'h14, 32'hBBBB0002, 0, 0);
        step(1, 32'h18, 32'hCCCC0003, 0, 1);
        chk("flush_valid", out_valid_o, 0);
        chk("flush_inst", instruction_o, NOP);
        chk("flush_ready", in_ready_o, 1);
        step(0, 32'h0, 32'h0, 1, 0);

        // Flush coinciding with an output fire
        step(1, 32'h20, 32'hDDDD0004, 0, 0);
        step(0, 32'h0, 32'h0, 1, 1);
        chk("flush_fire_valid", out_valid_o, 0);
        step(0, 32'h0, 32'h0, 1, 0);
        chk("no_dup_valid", out_valid_o, 0);

        // Random traffic with sparse flushes
        verbose = 1'b0;
        pc      = 32'h1000;
        for (int i = 0; i < 10000; i++) begin
            rv = ($urandom_range(0, 99) < 60);
            ro = ($urandom_range(0, 99) < 60);
            rf = ($urandom_range(0, 99) < 3);
            step(rv, pc, $urandom, ro, rf);
            if (rv) pc = pc + 32'd4;
        end
        repeat (3) step(0, 32'h0, 32'h0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
